// File: rtl/mem_write_checker_if.sv
// Bus bundle for the write checker: the expected-entry push handshake
// and the observed CPU data-memory write port.
interface mem_write_checker_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
);
  logic              exp_valid;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_data;
  logic              exp_ready;
  logic              we;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] cpu_out_m;

  // Stimulus side: offers expected entries and drives the observed writes.
  modport master (
    output exp_valid, exp_addr, exp_data, we, ram_address, cpu_out_m,
    input  exp_ready
  );

  // Checker side.
  modport slave (
    input  exp_valid, exp_addr, exp_data, we, ram_address, cpu_out_m,
    output exp_ready
  );
endinterface

// File: rtl/mem_write_checker.sv
// Memory write checker: queues expected (address, data) writes in a FIFO
// and compares each observed CPU data-memory write against the FIFO head
// with zero latency. Ends in a sticky PASS or FAIL state with the first
// failing transaction captured.
module mem_write_checker #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic                     Clk,
  input  logic                     Reset,
  mem_write_checker_if.slave       bus,
  input  logic                     done_in,
  output logic                     pass,
  output logic                     fail,
  output logic [2:0]               err_code,
  output logic [ADDR_W-1:0]        err_addr,
  output logic [DATA_W-1:0]        err_exp_data,
  output logic [DATA_W-1:0]        err_got_data,
  output logic [15:0]              match_cnt,
  output logic [$clog2(DEPTH):0]   pending
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_CHECK = 2'd0,
    ST_PASS  = 2'd1,
    ST_FAIL  = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_ADDR    = 3'd1,
    ERR_DATA    = 3'd2,
    ERR_UNEXP   = 3'd3,
    ERR_MISSING = 3'd4
  } err_e;

  state_e            state, nxt_state;
  err_e              err_q, nxt_err;
  logic [ADDR_W-1:0] nxt_err_addr;
  logic [DATA_W-1:0] nxt_err_exp, nxt_err_got;
  logic              match;

  // Expected-entry FIFO storage and pointers.
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, next_head_ptr;
  logic [CNT_W-1:0]  count, post_pop_count;

  logic              full, empty, push, pop;
  logic [ADDR_W-1:0] head_addr, next_head_addr;
  logic [DATA_W-1:0] head_data, next_head_data;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // Accept only while checking, with room, and not on the end-of-test
  // cycle; Reset forces it low so nothing is queued during reset.
  assign bus.exp_ready = (state == ST_CHECK) && !full && !done_in && !Reset;

  assign push = bus.exp_valid && bus.exp_ready;
  assign pop  = (state == ST_CHECK) && bus.we && !empty;

  assign head_addr = addr_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  // Entry that would be at the head once this cycle's pop is applied;
  // it is the first missing write when done_in arrives.
  assign next_head_ptr  = rd_ptr + PTR_W'(pop);
  assign next_head_addr = addr_mem[next_head_ptr];
  assign next_head_data = data_mem[next_head_ptr];
  assign post_pop_count = count - CNT_W'(pop);

  // Next-state and failure-capture decode; the same-cycle write is judged
  // before done_in so a write failure code always wins.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path
    // leaves one unassigned, which would infer a latch.
    nxt_state    = state;
    nxt_err      = err_q;
    nxt_err_addr = err_addr;
    nxt_err_exp  = err_exp_data;
    nxt_err_got  = err_got_data;
    match        = 1'b0;

    if (state == ST_CHECK) begin
      if (bus.we) begin
        if (empty) begin
          nxt_state    = ST_FAIL;
          nxt_err      = ERR_UNEXP;
          nxt_err_addr = bus.ram_address;
          nxt_err_exp  = '0;
          nxt_err_got  = bus.cpu_out_m;
        end else if (head_addr != bus.ram_address) begin
          nxt_state    = ST_FAIL;
          nxt_err      = ERR_ADDR;
          nxt_err_addr = bus.ram_address;
          nxt_err_exp  = head_data;
          nxt_err_got  = bus.cpu_out_m;
        end else if (head_data != bus.cpu_out_m) begin
          nxt_state    = ST_FAIL;
          nxt_err      = ERR_DATA;
          nxt_err_addr = bus.ram_address;
          nxt_err_exp  = head_data;
          nxt_err_got  = bus.cpu_out_m;
        end else begin
          match = 1'b1;
        end
      end

      if (done_in && (nxt_state == ST_CHECK)) begin
        if (post_pop_count == '0) begin
          nxt_state = ST_PASS;
        end else begin
          nxt_state    = ST_FAIL;
          nxt_err      = ERR_MISSING;
          nxt_err_addr = next_head_addr;
          nxt_err_exp  = next_head_data;
          nxt_err_got  = bus.cpu_out_m;
        end
      end
    end
  end

  // Control state: FSM, sticky flags, captured failure, match counter and
  // FIFO pointers/occupancy.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (Reset) begin
      state        <= ST_CHECK;
      pass         <= 1'b0;
      fail         <= 1'b0;
      err_q        <= ERR_NONE;
      err_addr     <= '0;
      err_exp_data <= '0;
      err_got_data <= '0;
      match_cnt    <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
    end else begin
      state        <= nxt_state;
      pass         <= (nxt_state == ST_PASS);
      fail         <= (nxt_state == ST_FAIL);
      err_q        <= nxt_err;
      err_addr     <= nxt_err_addr;
      err_exp_data <= nxt_err_exp;
      err_got_data <= nxt_err_got;
      if (match && (match_cnt != 16'hFFFF)) begin
        match_cnt <= match_cnt + 16'd1;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage write port.
  always_ff @(posedge Clk) begin
    // NOTE: storage is deliberately not reset; occupancy and pointers
    // define which words are valid, so stale contents are never read.
    if (push) begin
      addr_mem[wr_ptr] <= bus.exp_addr;
      data_mem[wr_ptr] <= bus.exp_data;
    end
  end

  assign err_code = err_q;
  assign pending  = count;

endmodule

// File: tb/tb_mem_write_checker.sv
// Self-checking bench for mem_write_checker: a table of directed vectors
// plus hand-written full/wrap and mid-test reset sequences.
module tb_mem_write_checker;

  localparam int AW    = 15;
  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int PW    = $clog2(DEPTH) + 1;

  logic          Clk;
  logic          Reset;
  logic          done_in;
  logic          pass, fail;
  logic [2:0]    err_code;
  logic [AW-1:0] err_addr;
  logic [DW-1:0] err_exp_data, err_got_data;
  logic [15:0]   match_cnt;
  logic [PW-1:0] pending;

  mem_write_checker_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_write_checker #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .bus          (bus),
    .done_in      (done_in),
    .pass         (pass),
    .fail         (fail),
    .err_code     (err_code),
    .err_addr     (err_addr),
    .err_exp_data (err_exp_data),
    .err_got_data (err_got_data),
    .match_cnt    (match_cnt),
    .pending      (pending)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic          rst, ev;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          we;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    logic          dn;
    logic          x_rdy;
    logic [PW-1:0] x_pend;
    logic          x_pass, x_fail;
    logic [2:0]    x_code;
    logic [15:0]   x_mcnt;
    logic [AW-1:0] x_eaddr;
    logic [DW-1:0] x_eexp, x_egot;
  } vec_t;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } entry_t;

  function automatic vec_t v(input int rst, ev, ea, ed, we, ra, rd, dn,
                             rdy, pend, ps, fl, cd, mc, xa, xe, xg);
    vec_t r;
    r.rst = 1'(rst);  r.ev = 1'(ev);  r.ea = AW'(ea);  r.ed = DW'(ed);
    r.we = 1'(we);    r.ra = AW'(ra); r.rd = DW'(rd);  r.dn = 1'(dn);
    r.x_rdy = 1'(rdy); r.x_pend = PW'(pend); r.x_pass = 1'(ps); r.x_fail = 1'(fl);
    r.x_code = 3'(cd); r.x_mcnt = 16'(mc); r.x_eaddr = AW'(xa);
    r.x_eexp = DW'(xe); r.x_egot = DW'(xg);
    return r;
  endfunction

  task automatic idle();
    Reset = 1'b0; done_in = 1'b0;
    bus.exp_valid = 1'b0; bus.exp_addr = '0; bus.exp_data = '0;
    bus.we = 1'b0; bus.ram_address = '0; bus.cpu_out_m = '0;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
  endtask

  // Drive one vector, check the combinational ready before the edge and
  // the registered outputs just after it.
  task automatic apply(input int idx, input vec_t t);
    Reset = t.rst; bus.exp_valid = t.ev; bus.exp_addr = t.ea; bus.exp_data = t.ed;
    bus.we = t.we; bus.ram_address = t.ra; bus.cpu_out_m = t.rd; done_in = t.dn;
    #2;
    check($sformatf("row%0d_exp_ready", idx), 32'(bus.exp_ready), 32'(t.x_rdy));
    step();
    check($sformatf("row%0d_pending", idx), 32'(pending), 32'(t.x_pend));
    check($sformatf("row%0d_pass", idx), 32'(pass), 32'(t.x_pass));
    check($sformatf("row%0d_fail", idx), 32'(fail), 32'(t.x_fail));
    check($sformatf("row%0d_err_code", idx), 32'(err_code), 32'(t.x_code));
    check($sformatf("row%0d_match_cnt", idx), 32'(match_cnt), 32'(t.x_mcnt));
    check($sformatf("row%0d_err_addr", idx), 32'(err_addr), 32'(t.x_eaddr));
    check($sformatf("row%0d_err_exp_data", idx), 32'(err_exp_data), 32'(t.x_eexp));
    check($sformatf("row%0d_err_got_data", idx), 32'(err_got_data), 32'(t.x_egot));
    check($sformatf("row%0d_exclusive", idx), 32'(pass & fail), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t   vecs[$];
    entry_t model[$];
    entry_t e;
    int     next_id;
    int     matched;
    logic   exp_rdy;

    idle();

    //          rst ev ea      ed       we ra      rd       dn  rdy pend ps fl cd mc xaddr  xexp     xgot
    // Happy path
    vecs.push_back(v(1, 0, 0,      0,       0, 0,      0,       0,  0,  0,  0, 0, 0, 0, 0,     0,       0));
    vecs.push_back(v(0, 1, 'h10,   'h1234,  0, 0,      0,       0,  1,  1,  0, 0, 0, 0, 0,     0,       0));
    vecs.push_back(v(0, 1, 'h11,   'h5678,  0, 0,      0,       0,  1,  2,  0, 0, 0, 0, 0,     0,       0));
    vecs.push_back(v(0, 0, 0,      0,       1, 'h10,   'h1234,  0,  1,  1,  0, 0, 0, 1, 0,     0,       0));
    vecs.push_back(v(0, 0, 0,      0,       1, 'h11,   'h5678,  0,  1,  0,  0, 0, 0, 2, 0,     0,       0));
    vecs.push_back(v(0, 0, 0,      0,       0, 0,      0,       1,  0,  0,  1, 0, 0, 2, 0,     0,       0));
    vecs.push_back(v(0, 1, 'h12,   'h9,     1, 'h12,   'h9,     1,  0,  0,  1, 0, 0, 2, 0,     0,       0));
    // Data mismatch; later write leaves the capture unchanged
    vecs.push_back(v(1, 0, 0,      0,       0, 0,      0,       0,  0,  0,  0, 0, 0, 0, 0,     0,       0));
    vecs.push_back(v(0, 1, 'h20,   'hAAAA,  0, 0,      0,       0,  1,  1,  0, 0, 0, 0, 0,     0,       0));
    vecs.push_back(v(0, 0, 0,      0,       1, 'h20,   'hAAAB,  0,  1,  0,  0, 1, 2, 0, 'h20,  'hAAAA,  'hAAAB));
    vecs.push_back(v(0, 1, 'h40,   'h2,     1, 'h30,   'h1111,  0,  0,  0,  0, 1, 2, 0, 'h20,  'hAAAA,  'hAAAB));
    // Unexpected write with a same-cycle push (no bypass)
    vecs.push_back(v(1, 0, 0,      0,       0, 0,      0,       0,  0,  0,  0, 0, 0, 0, 0,     0,       0));
    vecs.push_back(v(0, 1, 'h07,   'h9,     1, 'h05,   'h1,     0,  1,  1,  0, 1, 3, 0, 'h05,  0,       'h1));
    // Missing writes
    vecs.push_back(v(1, 0, 0,      0,       0, 0,      0,       0,  0,  0,  0, 0, 0, 0, 0,     0,       0));
    vecs.push_back(v(0, 1, 'h31,   'h0101,  0, 0,      0,       0,  1,  1,  0, 0, 0, 0, 0,     0,       0));
    vecs.push_back(v(0, 1, 'h32,   'h0202,  0, 0,      0,       0,  1,  2,  0, 0, 0, 0, 0,     0,       0));
    vecs.push_back(v(0, 1, 'h33,   'h0303,  0, 0,      0,       0,  1,  3,  0, 0, 0, 0, 0,     0,       0));
    vecs.push_back(v(0, 0, 0,      0,       1, 'h31,   'h0101,  0,  1,  2,  0, 0, 0, 1, 0,     0,       0));
    vecs.push_back(v(0, 0, 0,      0,       0, 0,      0,       1,  0,  2,  0, 1, 4, 1, 'h32,  'h0202,  0));
    // Address mismatch outranks data mismatch
    vecs.push_back(v(1, 0, 0,      0,       0, 0,      0,       0,  0,  0,  0, 0, 0, 0, 0,     0,       0));
    vecs.push_back(v(0, 1, 'h44,   'h5555,  0, 0,      0,       0,  1,  1,  0, 0, 0, 0, 0,     0,       0));
    vecs.push_back(v(0, 0, 0,      0,       1, 'h45,   'h5556,  0,  1,  0,  0, 1, 1, 0, 'h45,  'h5555,  'h5556));
    // done_in with the last matching write in the same cycle
    vecs.push_back(v(1, 0, 0,      0,       0, 0,      0,       0,  0,  0,  0, 0, 0, 0, 0,     0,       0));
    vecs.push_back(v(0, 1, 'h50,   'h0A0A,  0, 0,      0,       0,  1,  1,  0, 0, 0, 0, 0,     0,       0));
    vecs.push_back(v(0, 0, 0,      0,       1, 'h50,   'h0A0A,  1,  0,  0,  1, 0, 0, 1, 0,     0,       0));
    // done_in with a failing write: write failure code wins
    vecs.push_back(v(1, 0, 0,      0,       0, 0,      0,       0,  0,  0,  0, 0, 0, 0, 0,     0,       0));
    vecs.push_back(v(0, 1, 'h60,   'h1,     0, 0,      0,       0,  1,  1,  0, 0, 0, 0, 0,     0,       0));
    vecs.push_back(v(0, 0, 0,      0,       1, 'h60,   'h2,     1,  0,  0,  0, 1, 2, 0, 'h60,  'h1,     'h2));
    // done_in with a matching write but entries left: post-pop head reported
    vecs.push_back(v(1, 0, 0,      0,       0, 0,      0,       0,  0,  0,  0, 0, 0, 0, 0,     0,       0));
    vecs.push_back(v(0, 1, 'h70,   'h7,     0, 0,      0,       0,  1,  1,  0, 0, 0, 0, 0,     0,       0));
    vecs.push_back(v(0, 1, 'h71,   'h8,     0, 0,      0,       0,  1,  2,  0, 0, 0, 0, 0,     0,       0));
    vecs.push_back(v(0, 0, 0,      0,       1, 'h70,   'h7,     1,  0,  1,  0, 1, 4, 1, 'h71,  'h8,     'h7));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(i, vecs[i]);
    end

    // Full and pointer wrap: fill, then sustain write+push, then drain.
    do_reset();
    next_id = 0;
    matched = 0;
    for (int i = 0; i < DEPTH; i++) begin
      bus.exp_valid = 1'b1;
      bus.exp_addr  = AW'(next_id);
      bus.exp_data  = DW'(16'hC000 ^ next_id);
      #2;
      check("fill_exp_ready", 32'(bus.exp_ready), 32'd1);
      step();
      e.a = AW'(next_id); e.d = DW'(16'hC000 ^ next_id);
      model.push_back(e);
      next_id++;
    end
    check("full_pending", 32'(pending), 32'(DEPTH));
    bus.exp_addr = AW'(next_id);
    bus.exp_data = DW'(16'hC000 ^ next_id);
    #2;
    check("full_exp_ready", 32'(bus.exp_ready), 32'd0);

    for (int c = 0; c < 3 * DEPTH; c++) begin
      bus.exp_valid   = 1'b1;
      bus.exp_addr    = AW'(next_id);
      bus.exp_data    = DW'(16'hC000 ^ next_id);
      bus.we          = 1'b1;
      bus.ram_address = model[0].a;
      bus.cpu_out_m   = model[0].d;
      #1;
      exp_rdy = (model.size() < DEPTH);
      check("wrap_exp_ready", 32'(bus.exp_ready), 32'(exp_rdy));
      @(posedge Clk);
      #1;
      void'(model.pop_front());
      matched++;
      if (exp_rdy) begin
        e.a = AW'(next_id); e.d = DW'(16'hC000 ^ next_id);
        model.push_back(e);
        next_id++;
      end
      check("wrap_pending", 32'(pending), 32'(model.size()));
      check("wrap_pending_range", 32'(pending >= PW'(DEPTH - 1)), 32'd1);
      check("wrap_no_fail", 32'(fail), 32'd0);
    end

    bus.exp_valid = 1'b0;
    for (int c = 0; c < DEPTH && model.size() > 0; c++) begin
      bus.we          = 1'b1;
      bus.ram_address = model[0].a;
      bus.cpu_out_m   = model[0].d;
      step();
      void'(model.pop_front());
      matched++;
      check("drain_pending", 32'(pending), 32'(model.size()));
    end
    bus.we  = 1'b0;
    done_in = 1'b1;
    step();
    done_in = 1'b0;
    check("wrap_pass", 32'(pass), 32'd1);
    check("wrap_fail", 32'(fail), 32'd0);
    check("wrap_match_cnt", 32'(match_cnt), 32'(matched));

    // Reset mid-test discards queued entries.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus.exp_valid = 1'b1;
      bus.exp_addr  = AW'(16'h100 + i);
      bus.exp_data  = DW'(i);
      step();
    end
    check("mid_pending_before", 32'(pending), 32'd5);
    Reset = 1'b1;
    #2;
    check("mid_reset_exp_ready", 32'(bus.exp_ready), 32'd0);
    step();
    Reset = 1'b0;
    bus.exp_valid = 1'b0;
    check("mid_pending_after", 32'(pending), 32'd0);
    check("mid_fail_after", 32'(fail), 32'd0);
    done_in = 1'b1;
    step();
    done_in = 1'b0;
    check("mid_pass", 32'(pass), 32'd1);
    check("mid_match_cnt", 32'(match_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_write_checker.md
MEM_WRITE_CHECKER -- requirements
Module: mem_write_checker

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, meaning data-memory address width.
REQ-002 SHALL have parameter DATA_W, default 16, meaning data-memory word width.
REQ-003 SHALL have parameter DEPTH, default 16, meaning expected-entry FIFO depth (power of 2, >=2).
REQ-004 SHALL have port Clk, input, 1, the single clock, with all state updated on its rising edge.
REQ-005 SHALL have port Reset, input, 1, a synchronous active-high reset.
REQ-006 SHALL have port exp_valid, input, 1, meaning an expected write entry is offered.
REQ-007 SHALL have port exp_addr, input, ADDR_W, meaning the expected write address.
REQ-008 SHALL have port exp_data, input, DATA_W, meaning the expected write data.
REQ-009 SHALL have port exp_ready, output, 1, meaning the checker accepts the offered entry this cycle.
REQ-010 SHALL have port we, input, 1, meaning the observed CPU data-memory write enable.
REQ-011 SHALL have port ram_address, input, ADDR_W, meaning the observed write address.
REQ-012 SHALL have port cpu_out_m, input, DATA_W, meaning the observed write data.
REQ-013 SHALL have port done_in, input, 1, a one-cycle pulse meaning end of test.
REQ-014 SHALL have port pass, output, 1, a sticky pass flag.
REQ-015 SHALL have port fail, output, 1, a sticky fail flag.
REQ-016 SHALL have port err_code, output, 3, giving the failure cause: 0 none, 1 address mismatch, 2 data mismatch, 3 unexpected write, 4 missing writes.
REQ-017 SHALL have ports err_addr (ADDR_W), err_exp_data (DATA_W) and err_got_data (DATA_W), all outputs, holding the failing transaction.
REQ-018 SHALL have port match_cnt, output, 16, counting matched writes.
REQ-019 SHALL have port pending, output, $clog2(DEPTH)+1, giving FIFO occupancy.

Function
REQ-020 SHALL implement a three-state FSM with states CHECK, PASS and FAIL, where PASS and FAIL are terminal until Reset.
REQ-021 SHALL set exp_ready = (state==CHECK) && !full && !done_in.
- A push occurs on exp_valid && exp_ready.
- Entries are stored in FIFO order.
REQ-022 SHALL, in CHECK with we=1 and the FIFO non-empty, pop the head and compare it against the observed write in the same cycle, with zero compare latency; results are visible on the outputs the next cycle.
REQ-023 SHALL prioritise the compare result as follows: address mismatch (code 1) over data mismatch (code 2); on a full match, match_cnt increments, saturating at 16'hFFFF.
REQ-024 SHALL, on we=1 with the FIFO empty, go to FAIL with code 3; a same-cycle push is not bypassed to the compare.
REQ-025 SHALL, on entering FAIL, capture err_addr=ram_address, err_exp_data=head data (0 for code 3) and err_got_data=cpu_out_m.
REQ-026 SHALL allow a push and a pop in the same cycle, including when the FIFO is full (pop frees space next cycle only; exp_ready follows REQ-021); pending is unchanged in that case.
REQ-027 SHALL handle done_in in CHECK as follows:
- The same-cycle write is checked first.
- If that write fails, the write failure code wins.
- Otherwise, post-pop occupancy 0 -> PASS; otherwise -> FAIL with code 4, err_exp_data=head data and err_addr=head addr.
REQ-028 SHALL, in PASS or FAIL, ignore we, exp_valid and done_in, and freeze all counters, FIFO and err_* fields.
REQ-029 SHALL ensure pass and fail are never both 1, and that each is registered and high exactly while the FSM is in its state.
REQ-030 SHALL wrap FIFO pointers modulo DEPTH, distinguishing full from empty via occupancy.

Reset
REQ-031 SHALL, on Reset=1 at a rising Clk edge, go to CHECK and set: FIFO empty, pending=0, exp_ready=0 during the reset cycle, pass=0, fail=0, err_code=0, err_* fields=0, match_cnt=0.
REQ-032 SHALL give Reset priority over all inputs, so that an assertion mid-operation (including in PASS or FAIL) discards all pending entries.

Verification
REQ-033 SHALL be verified by the happy path: push (0x10,0x1234),(0x11,0x5678); writes in the same order; done_in -> pass=1, match_cnt=2, pending=0.
REQ-034 SHALL be verified by a data mismatch: push (0x20,0xAAAA); write (0x20,0xAAAB) -> fail=1, err_code=2, err_addr=0x20, err_exp_data=0xAAAA, err_got_data=0xAAAB; a later write leaves the err_* fields unchanged.
REQ-035 SHALL be verified by an unexpected write: with the FIFO empty, drive we with (0x05,0x0001) together with a same-cycle push -> fail=1, err_code=3, pending=1.
REQ-036 SHALL be verified by missing writes: push 3 entries, match 1 write, then done_in -> fail=1, err_code=4, err_addr = the 2nd entry's address.
REQ-037 SHALL be verified by full/wrap: push DEPTH entries -> exp_ready=0; simultaneous write+push held for 3*DEPTH cycles -> pending stays DEPTH-1 or DEPTH with no loss; all writes match; done_in after draining -> pass=1.
REQ-038 SHALL be verified by reset mid-test: push 5 entries, assert Reset for 1 cycle -> pending=0 and fail=0; a subsequent done_in -> pass=1.
